// File: rtl/spi_fsm_controller.sv
// SPI slave sequencer: address frame (7-bit addr + R/W LSB) then one data frame; strobes decode registered state, 1 clk after the causing edge, no backpressure.
// Optional SPI_FSM_ABORT_FLAG_EN adds a sticky abortFlag that records a CS-abort of the current transaction.
module spi_fsm_controller #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chipSelect,
  input  logic       peripheralClkEdge,
  input  logic       readWriteBit,
  output logic       addrLatchEnable,
  output logic       shiftRegParallelLoad,
  output logic       dataMemWriteEnable,
  output logic       misoBufferEnable,
  output logic       busy,
`ifdef SPI_FSM_ABORT_FLAG_EN
  output logic       abortFlag,
`endif
  output logic [2:0] state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    GET_ADDR     = 3'd1,
    LATCH_ADDR   = 3'd2,
    READ_LOAD    = 3'd3,
    READ_SHIFT   = 3'd4,
    WRITE_SHIFT  = 3'd5,
    WRITE_COMMIT = 3'd6,
    DONE         = 3'd7
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_bit_cnt;
  logic          w_counting;
  logic          w_last_edge;
  logic          w_abort;

  assign w_counting  = (r_state == GET_ADDR) || (r_state == READ_SHIFT) || (r_state == WRITE_SHIFT);
  assign w_last_edge = peripheralClkEdge && (r_bit_cnt == LAST_BIT);
  // WRITE_COMMIT and DONE are deliberately absent: a completed frame cannot be aborted.
  assign w_abort     = chipSelect && (r_state inside {GET_ADDR, LATCH_ADDR, READ_LOAD,
                                                      READ_SHIFT, WRITE_SHIFT});

  always_comb begin
    w_next_state = r_state;
    if (w_abort) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:         if (!chipSelect) w_next_state = GET_ADDR;
        GET_ADDR:     if (w_last_edge) w_next_state = LATCH_ADDR;
        LATCH_ADDR:   w_next_state = readWriteBit ? READ_LOAD : WRITE_SHIFT;
        READ_LOAD:    w_next_state = READ_SHIFT;
        READ_SHIFT:   if (w_last_edge) w_next_state = DONE;
        WRITE_SHIFT:  if (w_last_edge) w_next_state = WRITE_COMMIT;
        WRITE_COMMIT: w_next_state = chipSelect ? IDLE : DONE;
        DONE:         if (chipSelect) w_next_state = IDLE;
        default:      w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      // Any state change clears the counter, which covers entry to every counting state.
      if (w_next_state != r_state) begin
        r_bit_cnt <= '0;
      end else if (w_counting && peripheralClkEdge) begin
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end
    end
  end

  assign addrLatchEnable      = (r_state == LATCH_ADDR);
  assign shiftRegParallelLoad = (r_state == READ_LOAD);
  assign dataMemWriteEnable   = (r_state == WRITE_COMMIT);
  assign misoBufferEnable     = (r_state == READ_SHIFT);
  assign busy                 = (r_state != IDLE);
  assign state                = r_state;

`ifdef SPI_FSM_ABORT_FLAG_EN
  logic r_abort_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_abort_flag <= 1'b0;
    end else if (w_abort) begin
      r_abort_flag <= 1'b1;
    end else if ((r_state == IDLE) && !chipSelect) begin
      r_abort_flag <= 1'b0;
    end
  end

  assign abortFlag = r_abort_flag;
`endif

endmodule

// File: tb/tb_spi_fsm_controller.sv
// Bench for spi_fsm_controller: random frames are expanded into an expected per-cycle timeline
// from the frame rules, then applied and checked cycle by cycle.
module tb_spi_fsm_controller;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_ADDR = 3'd1, ST_LATCH = 3'd2, ST_RLOAD = 3'd3,
                         ST_RSHIFT = 3'd4, ST_WSHIFT = 3'd5, ST_COMMIT = 3'd6, ST_DONE = 3'd7;
  // Strobe bundle order: {addrLatchEnable, shiftRegParallelLoad, dataMemWriteEnable, misoBufferEnable}
  localparam logic [3:0] S0 = 4'b0000, ALE = 4'b1000, PL = 4'b0100, WE = 4'b0010, MISO = 4'b0001;

  logic       clk = 1'b0;
  logic       reset, chipSelect, peripheralClkEdge, readWriteBit;
  logic       addrLatchEnable, shiftRegParallelLoad, dataMemWriteEnable, misoBufferEnable, busy;
  logic [2:0] state;
`ifdef SPI_FSM_ABORT_FLAG_EN
  logic       abortFlag;
`endif

  spi_fsm_controller #(.WIDTH(8)) dut (
    .clk                  (clk),
    .reset                (reset),
    .chipSelect           (chipSelect),
    .peripheralClkEdge    (peripheralClkEdge),
    .readWriteBit         (readWriteBit),
    .addrLatchEnable      (addrLatchEnable),
    .shiftRegParallelLoad (shiftRegParallelLoad),
    .dataMemWriteEnable   (dataMemWriteEnable),
    .misoBufferEnable     (misoBufferEnable),
    .busy                 (busy),
`ifdef SPI_FSM_ABORT_FLAG_EN
    .abortFlag            (abortFlag),
`endif
    .state                (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, cs, e, rw;
    logic [2:0] st;
    logic [3:0] sb;
    logic       ab;
  } vec_t;

  vec_t q[$];
  logic exp_ab;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // One cycle of inputs plus the outputs expected just after the clock edge that samples them.
  function automatic void add(logic r, logic c, logic e, logic w, logic [2:0] st, logic [3:0] sb);
    vec_t v;
    v.rst = r; v.cs = c; v.e = e; v.rw = w; v.st = st; v.sb = sb; v.ab = exp_ab;
    q.push_back(v);
  endfunction

  // n SCLK edges with random idle gaps; the n-th edge moves to st_end/sb_end.
  function automatic void edges(int n, logic [2:0] st, logic [3:0] sb,
                                logic [2:0] st_end, logic [3:0] sb_end);
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) add(1'b0, 1'b0, 1'b0, rnd(), st, sb);
      if (i == n - 1) add(1'b0, 1'b0, 1'b1, rnd(), st_end, sb_end);
      else            add(1'b0, 1'b0, 1'b1, rnd(), st, sb);
    end
  endfunction

  function automatic void abort_now();
    exp_ab = 1'b1;
    add(1'b0, 1'b1, rnd(), rnd(), ST_IDLE, S0);
  endfunction

  // abort_at: 0 none, 1 address, 2 latch, 3 read-load, 4 read-shift, 5 write-shift, 6 reset after 3 read edges
  function automatic void frame(logic rwb_in, int abort_at, logic commit_cs, int n_extra);
    logic rwb = rwb_in;
    int   k;
    if (abort_at == 3 || abort_at == 4 || abort_at == 6) rwb = 1'b1;
    if (abort_at == 5) rwb = 1'b0;
    add(1'b0, 1'b1, 1'b1, rnd(), ST_IDLE, S0);
    exp_ab = 1'b0;
    add(1'b0, 1'b0, 1'b1, rnd(), ST_ADDR, S0);   // edge coincident with the CS fall is not counted
    if (abort_at == 1) begin
      k = $urandom_range(0, 7);
      edges(k, ST_ADDR, S0, ST_ADDR, S0);
      abort_now();
      return;
    end
    edges(8, ST_ADDR, S0, ST_LATCH, ALE);
    if (abort_at == 2) begin abort_now(); return; end
    if (rwb) begin
      add(1'b0, 1'b0, rnd(), 1'b1, ST_RLOAD, PL);
      if (abort_at == 3) begin abort_now(); return; end
      add(1'b0, 1'b0, rnd(), rnd(), ST_RSHIFT, MISO);
      if (abort_at == 4) begin
        k = $urandom_range(0, 7);
        edges(k, ST_RSHIFT, MISO, ST_RSHIFT, MISO);
        abort_now();
        return;
      end
      if (abort_at == 6) begin
        edges(3, ST_RSHIFT, MISO, ST_RSHIFT, MISO);
        exp_ab = 1'b0;
        add(1'b1, rnd(), rnd(), rnd(), ST_IDLE, S0);
        return;
      end
      edges(8, ST_RSHIFT, MISO, ST_DONE, S0);
    end else begin
      add(1'b0, 1'b0, rnd(), 1'b0, ST_WSHIFT, S0);
      if (abort_at == 5) begin
        k = $urandom_range(0, 7);
        edges(k, ST_WSHIFT, S0, ST_WSHIFT, S0);
        abort_now();
        return;
      end
      edges(8, ST_WSHIFT, S0, ST_COMMIT, WE);
      if (commit_cs) begin
        add(1'b0, 1'b1, rnd(), rnd(), ST_IDLE, S0);
        return;
      end
      add(1'b0, 1'b0, rnd(), rnd(), ST_DONE, S0);
    end
    for (int i = 0; i < n_extra; i++) add(1'b0, 1'b0, 1'b1, rnd(), ST_DONE, S0);
    add(1'b0, 1'b1, rnd(), rnd(), ST_IDLE, S0);
  endfunction

  initial begin
    reset = 1'b1; chipSelect = 1'b1; peripheralClkEdge = 1'b0; readWriteBit = 1'b0;
    exp_ab = 1'b0;
    add(1'b1, 1'b1, 1'b1, 1'b0, ST_IDLE, S0);
    add(1'b1, 1'b0, 1'b1, 1'b1, ST_IDLE, S0);
    frame(1'b0, 0, 1'b0, 3);   // write frame with extra DONE edges
    frame(1'b1, 0, 1'b0, 3);   // read frame
    frame(1'b0, 1, 1'b0, 0);   // abort during address
    frame(1'b0, 0, 1'b0, 0);   // full frame right after an abort
    frame(1'b0, 0, 1'b1, 0);   // CS rises in the commit cycle
    frame(1'b1, 6, 1'b0, 0);   // reset mid-read
    frame(1'b1, 2, 1'b0, 0);
    frame(1'b0, 2, 1'b0, 0);
    frame(1'b1, 3, 1'b0, 0);
    frame(1'b1, 4, 1'b0, 0);
    frame(1'b0, 5, 1'b0, 1);
    for (int f = 0; f < 25; f++)
      frame(rnd(), $urandom_range(0, 6), rnd(), $urandom_range(0, 3));

    foreach (q[i]) begin
      reset             = q[i].rst;
      chipSelect        = q[i].cs;
      peripheralClkEdge = q[i].e;
      readWriteBit      = q[i].rw;
      @(posedge clk);
      #1;
      vectors++;
      assert ({state, busy, addrLatchEnable, shiftRegParallelLoad, dataMemWriteEnable, misoBufferEnable}
              === {q[i].st, (q[i].st != ST_IDLE), q[i].sb})
      else begin
        miscompares++;
        $error("FAIL outputs vec %0d: got state=%0d busy=%b strobes=%b, expected state=%0d busy=%b strobes=%b",
               i, state, busy,
               {addrLatchEnable, shiftRegParallelLoad, dataMemWriteEnable, misoBufferEnable},
               q[i].st, (q[i].st != ST_IDLE), q[i].sb);
      end
`ifdef SPI_FSM_ABORT_FLAG_EN
      vectors++;
      assert (abortFlag === q[i].ab)
      else begin
        miscompares++;
        $error("FAIL abortFlag vec %0d: got %b, expected %b", i, abortFlag, q[i].ab);
      end
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
